fetch_front_end: RTL

Fetch-side pipeline front end that consumes the hazard unit's stall/flush controls (PCWrite, IF_ID_Write, IF_Flush). It owns the program counter and the IF/ID pipeline register, and applies branch/jump redirects. It also keeps stall/flush statistics and a stall-watchdog flag for debug. It sits between instruction memory and the ID stage of the five-stage MIPS pipeline.

---
 rtl/fetch_front_end.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_front_end.sv
// Fetch front end: owns the PC and the IF/ID register, applies hazard-unit
// stall/flush controls and branch redirects, and keeps stall/flush statistics.
module fetch_front_end #(
   parameter int unsigned         PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter logic [PC_WIDTH-1:0] NOP       = '0,
   parameter int unsigned         CNT_WIDTH = 16,
   parameter int unsigned         MAX_STALL = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 PCWrite,
   input  logic                 IF_ID_Write,
   input  logic                 IF_Flush,
   input  logic [PC_WIDTH-1:0]  RedirectTarget,
   input  logic [PC_WIDTH-1:0]  Instruction_in,
   output logic [PC_WIDTH-1:0]  PC_out,
   output logic [PC_WIDTH-1:0]  IF_ID_Instruction,
   output logic [PC_WIDTH-1:0]  IF_ID_PCPlus4,
   output logic                 IF_ID_Valid,
   output logic [1:0]           FrontState,
   output logic [CNT_WIDTH-1:0] StallCount,
   output logic [CNT_WIDTH-1:0] FlushCount,
   output logic                 StallTimeout
);

   localparam int unsigned         RUN_W   = $clog2(MAX_STALL + 1);
   localparam logic [RUN_W-1:0]    RUN_MAX = RUN_W'(MAX_STALL);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STALL = 2'b10,
      ST_FLUSH = 2'b11
   } front_state_e;

   front_state_e         state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [PC_WIDTH-1:0]  instr_q, instr_d;
   logic [PC_WIDTH-1:0]  pcplus4_q, pcplus4_d;
   logic                 valid_q, valid_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic [RUN_W-1:0]     stall_run_q, stall_run_d;
   logic                 timeout_q, timeout_d;
   logic [PC_WIDTH-1:0]  pc_plus4;

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         instr_q     <= NOP;
         pcplus4_q   <= '0;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         stall_run_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         pcplus4_q   <= pcplus4_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         stall_run_q <= stall_run_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state: flush beats stall beats run
   always_comb begin
      pc_plus4    = pc_q + PC_WIDTH'(4);
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      pcplus4_d   = pcplus4_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      stall_run_d = stall_run_q;
      timeout_d   = timeout_q;

      if (IF_Flush) begin
         pc_d        = RedirectTarget & ~PC_WIDTH'(3);
         instr_d     = NOP;
         pcplus4_d   = '0;
         valid_d     = 1'b0;
         stall_run_d = '0;
         state_d     = ST_FLUSH;
         if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      end else if (!PCWrite || !IF_ID_Write) begin
         if (PCWrite) pc_d = pc_plus4;
         if (IF_ID_Write) begin
            instr_d   = Instruction_in;
            pcplus4_d = pc_plus4;
            valid_d   = 1'b1;
         end
         if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
         if (stall_run_q != RUN_MAX) stall_run_d = stall_run_q + RUN_W'(1);
         if (stall_run_d == RUN_MAX) timeout_d = 1'b1;
         state_d = ST_STALL;
      end else begin
         pc_d        = pc_plus4;
         instr_d     = Instruction_in;
         pcplus4_d   = pc_plus4;
         valid_d     = 1'b1;
         stall_run_d = '0;
         state_d     = ST_RUN;
      end
   end

   assign PC_out            = pc_q;
   assign IF_ID_Instruction = instr_q;
   assign IF_ID_PCPlus4     = pcplus4_q;
   assign IF_ID_Valid       = valid_q;
   assign FrontState        = state_q;
   assign StallCount        = stall_cnt_q;
   assign FlushCount        = flush_cnt_q;
   assign StallTimeout      = timeout_q;

endmodule
